// File: rtl/fifo_arb_pkg.sv
// Shared FSM state type and default parameters for the FIFO write arbiter.
// No logic lives here.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_MAX_BURST  = 4;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin pick: first requester with req high, searching from last_idx+1 and wrapping.
// Purely combinational, no backpressure.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_idx,
    output logic [NUM_REQ-1:0] pick_oh,
    output logic [IDX_W-1:0]   pick_idx,
    output logic               pick_vld
);

    always_comb begin
        int k;
        k        = 0;
        pick_oh  = '0;
        pick_idx = '0;
        pick_vld = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            k = (int'(last_idx) + off) % NUM_REQ;
            if (!pick_vld && req[k]) begin
                pick_vld    = 1'b1;
                pick_oh[k]  = 1'b1;
                pick_idx    = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter bursting up to MAX_BURST words per grant from NUM_REQ requesters into one FIFO.
// Latency: one IDLE arbitration cycle, first write the following cycle.
// Backpressure: fifo_full stalls the burst in place (no write, no ack) and blocks new grants.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy,
    output logic                          fifo_wr,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    input  logic                          fifo_full
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IW-1:0]        gidx_q, gidx_d;
    logic [IW-1:0]        last_grant_q, last_grant_d;
    logic [CW-1:0]        burst_cnt_q, burst_cnt_d;

    logic [NUM_REQ-1:0]   pick_oh;
    logic [IW-1:0]        pick_idx;
    logic                 pick_vld;
    logic                 req_g;
    logic                 wr;
    logic                 burst_last;
    logic [DATA_WIDTH-1:0] sel_data;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IW)
    ) u_rr_pick (
        .req      (req),
        .last_idx (last_grant_q),
        .pick_oh  (pick_oh),
        .pick_idx (pick_idx),
        .pick_vld (pick_vld)
    );

    // Granted requester's level and data, selected by the registered index.
    always_comb begin
        req_g    = 1'b0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gidx_q == IW'(i)) begin
                req_g    = req[i];
                sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign wr         = (state_q == BURST) && req_g && !fifo_full;
    assign burst_last = (burst_cnt_q == CW'(MAX_BURST - 1));

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        gidx_d       = gidx_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_vld && !fifo_full) begin
                    state_d      = BURST;
                    grant_d      = pick_oh;
                    gidx_d       = pick_idx;
                    last_grant_d = pick_idx;
                    burst_cnt_d  = '0;
                end
            end
            BURST: begin
                // A dropped request ends the burst; a full FIFO just holds everything.
                if (!req_g || (wr && burst_last)) begin
                    state_d     = IDLE;
                    grant_d     = '0;
                    burst_cnt_d = wr ? burst_cnt_q + 1'b1 : burst_cnt_q;
                end else if (wr) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            gidx_q       <= '0;
            last_grant_q <= IW'(NUM_REQ - 1);
            burst_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            gidx_q       <= gidx_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

    assign busy     = (state_q == BURST);
    assign grant    = grant_q;
    assign fifo_wr  = wr;
    assign ack      = wr ? grant_q : '0;
    assign fifo_din = busy ? sel_data : '0;

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of every requester data word and of the FIFO write data.
REQ-002 Parameter NUM_REQ, default 4: number of requesters, minimum 2.
REQ-003 Parameter MAX_BURST, default 4: maximum words written per grant, minimum 1.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 req  input  NUM_REQ  per-requester write request; level, held while the requester has a word.
REQ-007 req_data  input  NUM_REQ*DATA_WIDTH  flattened requester data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 ack  output  NUM_REQ  one-hot; ack[i]=1 means requester i's current word is written this cycle, and the requester presents its next word (or drops req) on the following cycle.
REQ-009 grant  output  NUM_REQ  one-hot registered grant vector; all zero when idle.
REQ-010 busy  output  1  high while in state BURST.
REQ-011 fifo_wr  output  1  write strobe to the FIFO.
REQ-012 fifo_din  output  DATA_WIDTH  write data to the FIFO.
REQ-013 fifo_full  input  1  FIFO full flag; a write issued while full is forbidden.

Function
REQ-014 The block SHALL implement a two-state FSM: IDLE and BURST.
REQ-015 In IDLE, when any req bit is high and fifo_full is low, the block SHALL register the winner chosen by round-robin and enter BURST on the next edge; otherwise it SHALL stay in IDLE.
REQ-016 Round-robin: search starts at index (last_grant+1) mod NUM_REQ and wraps; the first requester with req high wins.
REQ-017 last_grant SHALL update to the winner index on entry to BURST.
REQ-018 In BURST with granted index g: fifo_wr = req[g] & ~fifo_full, combinational from registered state and current inputs.
REQ-019 fifo_din SHALL equal req_data slice g whenever in BURST, and zero in IDLE.
REQ-020 ack SHALL equal grant when fifo_wr is high, and zero otherwise.
REQ-021 burst_cnt (width clog2(MAX_BURST+1)) SHALL clear on BURST entry and increment on every fifo_wr.
REQ-022 BURST->IDLE SHALL occur on the edge ending a cycle where: req[g] is low; or fifo_wr is high and burst_cnt == MAX_BURST-1.
REQ-023 While fifo_full is high in BURST with req[g] high, the block SHALL hold grant, burst_cnt, and state (stall, no write, no ack).
REQ-024 On return to IDLE, grant SHALL go to zero; at least one IDLE arbitration cycle separates consecutive grants.
REQ-025 Latency: a request in IDLE with FIFO not full SHALL produce its first fifo_wr/ack in the cycle after the arbitration cycle.
REQ-026 Requests from non-granted requesters SHALL have no effect until the next IDLE cycle.
REQ-027 A req bit dropping mid-burst for the granted requester SHALL end the burst with no write that cycle.

Reset
REQ-028 On rst, the block SHALL asynchronously enter IDLE; grant=0, ack=0, fifo_wr=0, fifo_din=0, busy=0, burst_cnt=0.
REQ-029 last_grant SHALL reset to NUM_REQ-1 so requester 0 has first priority.
REQ-030 Reset asserted mid-burst SHALL abort the burst immediately; no fifo_wr is issued while rst is high.

Structure
REQ-031 Package fifo_arb_pkg SHALL hold the FSM state enum (IDLE, BURST) and the default parameter constants.
REQ-032 The round-robin search SHALL be a combinational sub-module rr_pick (inputs req, last index; outputs one-hot winner, index, valid).

Verification
REQ-033 After reset, req=4'b0001, data0=0xA0..0xA5 streamed, FIFO not full -> 4 writes 0xA0-0xA3, one IDLE cycle, re-grant to 0, then 0xA4, 0xA5.
REQ-034 req=4'b1111 held continuously, MAX_BURST=4 -> grants cycle 0,1,2,3,0; each grant writes exactly 4 words, with one idle cycle between grants.
REQ-035 Requester 2 granted, fifo_full forced high for 3 cycles after its 2nd write -> no fifo_wr or ack for 3 cycles, grant held; 2 further writes complete the burst.
REQ-036 Requester 1 granted, req[1] drops after 1 write while req[3]=1 -> return to IDLE; requester 3 granted next; requester 1 wrote exactly 1 word.
REQ-037 rst asserted during the 2nd write of a burst -> outputs zero in the same cycle; after release, req=4'b1000 and req=4'b0001 both high -> requester 0 wins first.
REQ-038 fifo_full high in IDLE with req=4'b0100 -> no grant until fifo_full falls; grant to requester 2 on the next edge.
